// File: rtl/uart_word_rx.sv
// uart_word_rx: packs bytes from the UART receiver into WORD_LENGTH words for the core.
// Each byte is acknowledged with a one-cycle Clear_RX_Flag pulse. The finished word
// is offered with a word_valid/word_ack handshake, and overrun/parity status is sticky.
// Optional feature macro: RX_TIMEOUT_EN. When it is defined, a partial word is
// discarded after TIMEOUT_CYCLES idle cycles. When it is undefined, timeout_err is tied to 0.
module uart_word_rx #(
   parameter int unsigned WORD_LENGTH    = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [7:0]                             DATARX,
   input  logic                                   RX_FLAG,
   input  logic                                   ParityError,
   input  logic                                   word_ack,
   input  logic                                   clear_errors,
   output logic                                   Clear_RX_Flag,
   output logic [WORD_LENGTH-1:0]                 word_data,
   output logic                                   word_valid,
   output logic [$clog2(WORD_LENGTH/8+1)-1:0]     byte_count,
   output logic                                   overrun,
   output logic                                   parity_err,
   output logic                                   timeout_err
);

   localparam int unsigned BYTES = WORD_LENGTH / 8;
   localparam int unsigned CW    = $clog2(BYTES + 1);

   // Reject word widths that are not whole bytes, and a zero timeout.
   if (WORD_LENGTH == 0 || (WORD_LENGTH % 8) != 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("uart_word_rx: WORD_LENGTH must be a non-zero multiple of 8 and TIMEOUT_CYCLES non-zero");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_CLR = 2'd1,
      FULL     = 2'd2
   } state_t;

   state_t state;
   // Set when a byte has been dropped in FULL. It blocks a second drop until RX_FLAG falls.
   logic   drop_pend;

`ifdef RX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;
`else
   assign timeout_err = 1'b0;
`endif

   // Byte handshake, word assembly, handshake to the core, and sticky status.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         drop_pend     <= 1'b0;
         Clear_RX_Flag <= 1'b0;
         word_data     <= '0;
         word_valid    <= 1'b0;
         byte_count    <= '0;
         overrun       <= 1'b0;
         parity_err    <= 1'b0;
`ifdef RX_TIMEOUT_EN
         timeout_err   <= 1'b0;
         idle_cnt      <= '0;
`endif
      end else begin
         Clear_RX_Flag <= 1'b0;
`ifdef RX_TIMEOUT_EN
         idle_cnt      <= '0;
`endif
         // Clearing comes first, so that an error set in the same cycle overrides it.
         if (clear_errors) begin
            overrun     <= 1'b0;
            parity_err  <= 1'b0;
`ifdef RX_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
         end

         case (state)
            IDLE: begin
               if (RX_FLAG) begin
                  Clear_RX_Flag <= 1'b1;
                  state         <= WAIT_CLR;
                  if (ParityError) begin
                     byte_count <= '0;
                     parity_err <= 1'b1;
                  end else begin
                     for (int unsigned i = 0; i < BYTES; i++) begin
                        if (byte_count == CW'(i)) begin
                           word_data[i*8 +: 8] <= DATARX;
                        end
                     end
                     byte_count <= byte_count + CW'(1);
                  end
               end
`ifdef RX_TIMEOUT_EN
               // In IDLE, byte_count is always below BYTES, so a non-zero count means a partial word.
               else if (byte_count != '0) begin
                  if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                     byte_count  <= '0;
                     timeout_err <= 1'b1;
                  end else begin
                     idle_cnt <= idle_cnt + TW'(1);
                  end
               end
`endif
            end

            WAIT_CLR: begin
               if (!RX_FLAG && !Clear_RX_Flag) begin
                  if (byte_count == CW'(BYTES)) begin
                     state      <= FULL;
                     word_valid <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            FULL: begin
               if (!RX_FLAG && !Clear_RX_Flag) begin
                  drop_pend <= 1'b0;
               end
               if (word_ack) begin
                  word_valid <= 1'b0;
                  byte_count <= '0;
                  drop_pend  <= 1'b0;
                  // A byte dropped just before the ack may still be flagged. Wait for
                  // its flag to fall, so that the dropped byte is not taken as new data.
                  state      <= drop_pend ? WAIT_CLR : IDLE;
               end else if (RX_FLAG && !drop_pend) begin
                  overrun       <= 1'b1;
                  Clear_RX_Flag <= 1'b1;
                  drop_pend     <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_word_rx.sv
// tb_uart_word_rx: directed, table-driven bench for uart_word_rx (WORD_LENGTH=32, TIMEOUT_CYCLES=16).
module tb_uart_word_rx;

   localparam int unsigned WL = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    DATARX;
   logic          RX_FLAG;
   logic          ParityError;
   logic          word_ack;
   logic          clear_errors;
   logic          Clear_RX_Flag;
   logic [WL-1:0] word_data;
   logic          word_valid;
   logic [2:0]    byte_count;
   logic          overrun;
   logic          parity_err;
   logic          timeout_err;

   int checks   = 0;
   int failures = 0;

   uart_word_rx #(.WORD_LENGTH(WL), .TIMEOUT_CYCLES(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .DATARX        (DATARX),
      .RX_FLAG       (RX_FLAG),
      .ParityError   (ParityError),
      .word_ack      (word_ack),
      .clear_errors  (clear_errors),
      .Clear_RX_Flag (Clear_RX_Flag),
      .word_data     (word_data),
      .word_valid    (word_valid),
      .byte_count    (byte_count),
      .overrun       (overrun),
      .parity_err    (parity_err),
      .timeout_err   (timeout_err)
   );

   always #5 clk = ~clk;

   localparam logic [1:0] OP_BYTE = 2'd0;
   localparam logic [1:0] OP_ACK  = 2'd1;
   localparam logic [1:0] OP_CLR  = 2'd2;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  data;
      logic        pe;
      logic [2:0]  exp_bc;
      logic [31:0] exp_wd;
      logic        exp_wv;
      logic        exp_ov;
      logic        exp_pe;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Acts as the UART: keeps RX_FLAG high until the clear pulse is seen, then checks that the pulse lasted one cycle.
   task automatic send_byte(input logic [7:0] b, input logic pe);
      logic seen;
      DATARX      = b;
      ParityError = pe;
      RX_FLAG     = 1'b1;
      seen        = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (Clear_RX_Flag) seen = 1'b1;
      end
      check($sformatf("clr_seen_%02h", b), 32'(seen), 32'd1);
      RX_FLAG     = 1'b0;
      ParityError = 1'b0;
      @(negedge clk);
      check($sformatf("clr_width_%02h", b), 32'(Clear_RX_Flag), 32'd0);
      @(negedge clk);
   endtask

   task automatic do_ack();
      word_ack = 1'b1;
      @(negedge clk);
      word_ack = 1'b0;
   endtask

   task automatic do_clr();
      clear_errors = 1'b1;
      @(negedge clk);
      clear_errors = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_clr"}, 32'(Clear_RX_Flag), 32'd0);
      check({tag, "_wd"},  word_data,          32'd0);
      check({tag, "_wv"},  32'(word_valid),    32'd0);
      check({tag, "_bc"},  32'(byte_count),    32'd0);
      check({tag, "_ov"},  32'(overrun),       32'd0);
      check({tag, "_pe"},  32'(parity_err),    32'd0);
      check({tag, "_te"},  32'(timeout_err),   32'd0);
   endtask

   // Watchdog: stops a runaway simulation.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;

      // Table: each step's stimulus and the outputs expected after it.
      vecs[0]  = '{OP_BYTE, 8'h11, 1'b0, 3'd1, 32'h00000011, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{OP_BYTE, 8'h22, 1'b0, 3'd2, 32'h00002211, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{OP_BYTE, 8'h33, 1'b0, 3'd3, 32'h00332211, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{OP_BYTE, 8'h44, 1'b0, 3'd4, 32'h44332211, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{OP_BYTE, 8'h55, 1'b0, 3'd4, 32'h44332211, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{OP_CLR,  8'h00, 1'b0, 3'd4, 32'h44332211, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{OP_ACK,  8'h00, 1'b0, 3'd0, 32'h44332211, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{OP_BYTE, 8'hAA, 1'b0, 3'd1, 32'h443322AA, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{OP_BYTE, 8'hBB, 1'b0, 3'd2, 32'h4433BBAA, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{OP_BYTE, 8'hCC, 1'b1, 3'd0, 32'h4433BBAA, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{OP_BYTE, 8'h01, 1'b0, 3'd1, 32'h4433BB01, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{OP_BYTE, 8'h02, 1'b0, 3'd2, 32'h44330201, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{OP_BYTE, 8'h03, 1'b0, 3'd3, 32'h44030201, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{OP_BYTE, 8'h04, 1'b0, 3'd4, 32'h04030201, 1'b1, 1'b0, 1'b1};
      vecs[14] = '{OP_CLR,  8'h00, 1'b0, 3'd4, 32'h04030201, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{OP_ACK,  8'h00, 1'b0, 3'd0, 32'h04030201, 1'b0, 1'b0, 1'b0};

      reset        = 1'b1;
      DATARX       = 8'h00;
      RX_FLAG      = 1'b0;
      ParityError  = 1'b0;
      word_ack     = 1'b0;
      clear_errors = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 16; k++) begin
         case (vecs[k].op)
            OP_BYTE: send_byte(vecs[k].data, vecs[k].pe);
            OP_ACK:  do_ack();
            default: do_clr();
         endcase
         check($sformatf("v%0d_bc", k), 32'(byte_count), 32'(vecs[k].exp_bc));
         check($sformatf("v%0d_wd", k), word_data,       vecs[k].exp_wd);
         check($sformatf("v%0d_wv", k), 32'(word_valid), 32'(vecs[k].exp_wv));
         check($sformatf("v%0d_ov", k), 32'(overrun),    32'(vecs[k].exp_ov));
         check($sformatf("v%0d_pe", k), 32'(parity_err), 32'(vecs[k].exp_pe));
      end

      // A word_ack and a new byte arrive in the same FULL cycle. The ack wins, and the byte is taken next cycle.
      send_byte(8'h10, 1'b0);
      send_byte(8'h11, 1'b0);
      send_byte(8'h12, 1'b0);
      send_byte(8'h13, 1'b0);
      check("sim_full_wv", 32'(word_valid), 32'd1);
      word_ack = 1'b1;
      RX_FLAG  = 1'b1;
      DATARX   = 8'h77;
      @(negedge clk);
      word_ack = 1'b0;
      check("sim_ack_wv",  32'(word_valid),    32'd0);
      check("sim_ack_bc",  32'(byte_count),    32'd0);
      check("sim_ack_clr", 32'(Clear_RX_Flag), 32'd0);
      @(negedge clk);
      check("sim_take_clr", 32'(Clear_RX_Flag), 32'd1);
      check("sim_take_bc",  32'(byte_count),    32'd1);
      check("sim_take_wd",  word_data,          32'h13121177);
      RX_FLAG = 1'b0;
      repeat (2) @(negedge clk);
      check("sim_ov", 32'(overrun), 32'd0);

      // Inter-byte timeout, with a boundary check one cycle before it expires.
      do_reset();
      send_byte(8'h99, 1'b0);
      check("to_start_bc", 32'(byte_count), 32'd1);
      repeat (15) @(negedge clk);
      check("to_15_bc", 32'(byte_count), 32'd1);
      @(negedge clk);
`ifdef RX_TIMEOUT_EN
      check("to_16_bc", 32'(byte_count),  32'd0);
      check("to_16_te", 32'(timeout_err), 32'd1);
`else
      check("to_16_bc", 32'(byte_count),  32'd1);
      check("to_16_te", 32'(timeout_err), 32'd0);
`endif

      // Reset after two bytes, with a byte pending. That byte is taken after reset and starts a new word.
      do_reset();
      send_byte(8'hA1, 1'b0);
      send_byte(8'hA2, 1'b0);
      check("rst_pre_bc", 32'(byte_count), 32'd2);
      reset   = 1'b1;
      RX_FLAG = 1'b1;
      DATARX  = 8'hA3;
      @(negedge clk);
      check_all_zero("rst_mid");
      reset = 1'b0;
      send_byte(8'hA3, 1'b0);
      send_byte(8'hB2, 1'b0);
      send_byte(8'hB3, 1'b0);
      send_byte(8'hB4, 1'b0);
      check("rst_new_wd", word_data,          32'hB4B3B2A3);
      check("rst_new_wv", 32'(word_valid),    32'd1);
      check("rst_new_bc", 32'(byte_count),    32'd4);

      // Overrun with RX_FLAG held high: only one byte is dropped, and only one clear pulse is sent.
      pulses  = 0;
      DATARX  = 8'hEE;
      RX_FLAG = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (Clear_RX_Flag) pulses++;
      end
      RX_FLAG = 1'b0;
      repeat (2) @(negedge clk);
      check("hold_pulses", 32'(pulses),     32'd1);
      check("hold_ov",     32'(overrun),    32'd1);
      check("hold_wd",     word_data,       32'hB4B3B2A3);
      check("hold_wv",     32'(word_valid), 32'd1);
      do_clr();
      check("hold_clr_ov", 32'(overrun), 32'd0);
      do_ack();
      check("end_wv", 32'(word_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Receive-side bridge between the UART receiver and the MIPS core, the counterpart to the existing MIPS-to-UART transmit path (SerialData/SerialOutEn/TX_flag). It consumes bytes flagged by the UART (DATARX/RX_FLAG), acknowledges each with a one-cycle Clear_RX_Flag pulse, and packs them into a WORD_LENGTH word. The word is presented to the core with a valid/ack handshake, with sticky overrun and parity status. It runs in the clk_int domain next to the UART instance.

## Interface
- WORD_LENGTH, 32, assembled word width; must be a multiple of 8. BYTES = WORD_LENGTH/8 is derived.
- TIMEOUT_CYCLES, 1024, inter-byte timeout in clk cycles. Used only with RX_TIMEOUT_EN.
- clk  in  1  clock. One clock only.
- reset  in  1  synchronous, active-high reset.
- DATARX  in  8  received byte; valid while RX_FLAG=1.
- RX_FLAG  in  1  level flag from the UART; stays high until the UART sees Clear_RX_Flag.
- ParityError  in  1  parity status of the current byte; valid with RX_FLAG.
- word_ack  in  1  core has taken word_data.
- clear_errors  in  1  clears the sticky flags.
- Clear_RX_Flag  out  1  one-cycle pulse acknowledging a byte to the UART.
- word_data  out  WORD_LENGTH  assembled word. The first received byte goes in [7:0].
- word_valid  out  1  word_data is complete.
- byte_count  out  $clog2(BYTES+1)  bytes held in the current word.
- overrun  out  1  sticky: a byte was dropped while a word was pending.
- parity_err  out  1  sticky: a byte with a parity error was received.
- timeout_err  out  1  sticky: a partial word was discarded on timeout.

## Operation
- All outputs are registered. Reset drives every output to 0 and the state to IDLE.
- **IDLE**, RX_FLAG=1, ParityError=0:
  - Latch DATARX into byte slot byte_count.
  - Increment byte_count.
  - Pulse Clear_RX_Flag.
  - Go to WAIT_CLR.
- **IDLE**, RX_FLAG=1, ParityError=1:
  - Discard the byte.
  - Discard the partial word: byte_count←0, word_data unchanged.
  - Set parity_err and pulse Clear_RX_Flag.
  - Go to WAIT_CLR.
- **WAIT_CLR**:
  - Stay while RX_FLAG=1 or Clear_RX_Flag=1.
  - Otherwise go to FULL if byte_count=BYTES, else to IDLE.
  - This avoids consuming the same byte twice.
- **FULL**:
  - word_valid=1.
  - On word_ack: word_valid←0, byte_count←0, go to IDLE. word_data holds until the next byte is latched.
  - On RX_FLAG=1 without word_ack: discard the byte, set overrun, pulse Clear_RX_Flag, stay in FULL (wait for RX_FLAG low before another discard).
- **Simultaneous events**:
  - word_ack and RX_FLAG in the same FULL cycle: ack wins and there is no overrun. The byte is taken in IDLE on the next cycle.
  - word_ack outside FULL is ignored.
  - clear_errors in the same cycle as an error set: set wins.
- **Reset mid-word**: the partial word is lost and Clear_RX_Flag is 0 on the next cycle. Any pending UART byte is taken after reset.

## Timing
- Byte handshake, with RX_FLAG sampled high at edge N:
  - Slot written at edge N.
  - Clear_RX_Flag high during cycle N..N+1 only.
  - Earliest return to IDLE or FULL is edge N+2, given RX_FLAG is low by then.
- word_valid rises on the WAIT_CLR exit after the last byte. It falls at the edge that samples word_ack=1.
- Clear_RX_Flag is never high for two consecutive cycles.
- Throughput is one byte per 3 cycles minimum, far above the UART byte rate.

## Configuration
- RX_TIMEOUT_EN defined:
  - A counter runs in IDLE while 0<byte_count<BYTES and resets on every latched byte.
  - When it reaches TIMEOUT_CYCLES: byte_count←0, timeout_err set, state stays IDLE.
- RX_TIMEOUT_EN undefined: no counter, partial words are held indefinitely, and timeout_err is tied to 0.

## Test plan
- Reset, then bytes 0x11, 0x22, 0x33, 0x44 with no errors -> word_data=0x44332211, word_valid=1, byte_count=4, four Clear_RX_Flag pulses each one cycle wide; word_ack -> word_valid=0 next edge, byte_count=0.
- Word pending, extra byte 0x55 arrives -> Clear_RX_Flag pulse, overrun=1, word_data unchanged; clear_errors -> overrun=0.
- Bytes 0xAA, 0xBB, then 0xCC with ParityError=1 -> parity_err=1, byte_count=0; then 0x01..0x04 -> word_data=0x04030201.
- word_ack and RX_FLAG (byte 0x77) in the same FULL cycle -> overrun stays 0, byte_count=1, word_data[7:0]=0x77.
- RX_TIMEOUT_EN with TIMEOUT_CYCLES=16: send 0x99, then idle 16 cycles -> byte_count=0, timeout_err=1. Without the macro -> byte_count stays 1.
- Reset asserted after 2 bytes -> all outputs 0 next edge; 4 new bytes then assemble correctly.
